// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine: step modes and direction values.
package led_pattern_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ROTATE = 2'd0;
    localparam mode_t MODE_BOUNCE = 2'd1;
    localparam mode_t MODE_FILL   = 2'd2;
    localparam mode_t MODE_BLINK  = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/step_timer.sv
// Period counter for the LED pattern engine; raises tick on the last cycle of each period.
module step_timer #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_m1;

    // Period 0 behaves as 1; comparing with >= lets a lowered period take effect immediately.
    assign period_m1 = (period_i == '0) ? '0 : period_i - CNT_W'(1);
    assign tick_o    = run_i & (cnt_q >= period_m1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern generator: rotate, bounce, fill or blink an LED_W-bit pattern once per period.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int unsigned      LED_W    = 16,
    parameter int unsigned      CNT_W    = 27,
    parameter logic [LED_W-1:0] INIT_PAT = 16'hfffe
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run_i,
    input  logic [1:0]       mode_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             load_i,
    input  logic [LED_W-1:0] load_pat_i,
    output logic [LED_W-1:0] led_o,
    output logic             step_o,
    output logic             bounce_dir_o
);

    localparam int unsigned    PW     = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam logic [PW-1:0]  PosMax = PW'(LED_W - 1);

    logic [LED_W-1:0] led_q, led_d;
    logic [LED_W-1:0] pat_q, pat_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             tick;

    logic [LED_W-1:0] led_rol, led_ror, led_shl, led_shr;

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk      (clk),
        .resetn   (resetn),
        .run_i    (run_i),
        .clr_i    (load_i),
        .period_i (period_i),
        .tick_o   (tick)
    );

    assign led_rol = {led_q[LED_W-2:0], led_q[LED_W-1]};
    assign led_ror = {led_q[0], led_q[LED_W-1:1]};
    assign led_shl = {led_q[LED_W-2:0], 1'b0};
    assign led_shr = {1'b0, led_q[LED_W-1:1]};

    always_comb begin
        led_d  = led_q;
        pat_d  = pat_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        step_d = 1'b0;

        if (load_i) begin
            // Load outranks a coincident tick, which is simply dropped.
            led_d = load_pat_i;
            pat_d = load_pat_i;
            pos_d = '0;
            dir_d = dir_i;
        end else if (run_i) begin
            // Outside BOUNCE the internal direction shadows dir so entering BOUNCE starts in dir.
            if (mode_i != MODE_BOUNCE) begin
                dir_d = dir_i;
            end
            if (tick) begin
                step_d = 1'b1;
                unique case (mode_i)
                    MODE_ROTATE: begin
                        led_d = (dir_i == DIR_LEFT) ? led_rol : led_ror;
                    end
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_LEFT) begin
                            led_d = led_rol;
                            pos_d = (pos_q == PosMax) ? '0 : pos_q + PW'(1);
                            if (pos_d == PosMax) begin
                                dir_d = DIR_RIGHT;
                            end
                        end else begin
                            led_d = led_ror;
                            pos_d = (pos_q == '0) ? PosMax : pos_q - PW'(1);
                            if (pos_d == '0) begin
                                dir_d = DIR_LEFT;
                            end
                        end
                    end
                    MODE_FILL: begin
                        if (led_q == '0) begin
                            led_d = pat_q;
                        end else begin
                            led_d = (dir_i == DIR_LEFT) ? led_shl : led_shr;
                        end
                    end
                    MODE_BLINK: begin
                        led_d = ~led_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_q  <= INIT_PAT;
            pat_q  <= INIT_PAT;
            pos_q  <= '0;
            dir_q  <= DIR_LEFT;
            step_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            pat_q  <= pat_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign led_o        = led_q;
    assign step_o       = step_q;
    assign bounce_dir_o = dir_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: directed scenarios plus random traffic against a model.
module tb_led_pattern_engine;

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 27;
    localparam logic [W-1:0] INIT = 16'hfffe;

    logic             clk;
    logic             resetn;
    logic             run;
    logic [1:0]       mode;
    logic             dir;
    logic [CNT_W-1:0] period;
    logic             load;
    logic [W-1:0]     load_pat;
    logic [W-1:0]     led;
    logic             step;
    logic             bounce_dir;

    led_pattern_engine #(
        .LED_W    (W),
        .CNT_W    (CNT_W),
        .INIT_PAT (INIT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .run_i        (run),
        .mode_i       (mode),
        .dir_i        (dir),
        .period_i     (period),
        .load_i       (load),
        .load_pat_i   (load_pat),
        .led_o        (led),
        .step_o       (step),
        .bounce_dir_o (bounce_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       id;
        logic     step;
        logic [W-1:0] led;
        logic     bdir;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   vec_id = 0;

    // Reference state, kept as plain numbers
    logic [W-1:0] m_led, m_pat;
    int           m_cnt, m_pos;
    logic         m_dirq;

    // Advance the model by one clock using the inputs as currently driven, queue the expectation.
    task automatic model_step();
        exp_t e;
        int   p;
        bit   tk;
        tk = 1'b0;
        if (!resetn) begin
            m_led = INIT; m_pat = INIT; m_cnt = 0; m_pos = 0; m_dirq = 1'b0;
        end else if (load) begin
            m_led = load_pat; m_pat = load_pat; m_cnt = 0; m_pos = 0; m_dirq = dir;
        end else if (run) begin
            p  = (period == 0) ? 1 : int'(period);
            tk = (m_cnt >= p - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) begin
                case (mode)
                    2'd0: m_led = dir ? ((m_led >> 1) | (m_led << (W - 1)))
                                      : ((m_led << 1) | (m_led >> (W - 1)));
                    2'd1: begin
                        if (!m_dirq) begin
                            m_led = (m_led << 1) | (m_led >> (W - 1));
                            m_pos = (m_pos + 1) % W;
                            if (m_pos == W - 1) m_dirq = 1'b1;
                        end else begin
                            m_led = (m_led >> 1) | (m_led << (W - 1));
                            m_pos = (m_pos + W - 1) % W;
                            if (m_pos == 0) m_dirq = 1'b0;
                        end
                    end
                    2'd2: m_led = (m_led == 0) ? m_pat : (dir ? (m_led >> 1) : (m_led << 1));
                    default: m_led = ~m_led;
                endcase
            end
            if (mode != 2'd1) m_dirq = dir;
        end
        e.id = vec_id; e.step = tk; e.led = m_led; e.bdir = m_dirq;
        sb.push_back(e);
        vec_id++;
    endtask

    // Inputs change on the falling edge; the following rising edge consumes them.
    task automatic drive();
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_n(input int n);
        for (int i = 0; i < n; i++) drive();
    endtask

    // Monitor: one expectation per rising edge, compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (led !== e.led || step !== e.step || bounce_dir !== e.bdir) begin
                    miscompares++;
                    $display("FAIL vec%0d: led=%h step=%b bdir=%b, expected led=%h step=%b bdir=%b",
                             e.id, led, step, bounce_dir, e.led, e.step, e.bdir);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        resetn = 1'b0; run = 1'b1; mode = 2'd0; dir = 1'b0; period = 27'd3;
        load = 1'b0; load_pat = '0;
        m_led = INIT; m_pat = INIT; m_cnt = 0; m_pos = 0; m_dirq = 1'b0;
        @(negedge clk);

        // Reset, then rotate left with period 3
        drive_n(3);
        resetn = 1'b1;
        drive_n(8);

        // Rotate right for a full revolution
        dir = 1'b1; period = 27'd1;
        drive_n(18);

        // Bounce from a freshly loaded pattern, through the MSB end and back
        mode = 2'd1; dir = 1'b0; load = 1'b1; load_pat = 16'hfffe;
        drive();
        load = 1'b0;
        drive_n(34);

        // Fill left down to zero, then restart from the loaded pattern
        mode = 2'd2; load = 1'b1; load_pat = 16'hffff;
        drive();
        load = 1'b0;
        drive_n(20);
        dir = 1'b1;
        drive_n(20);

        // Blink with period 0 toggles every cycle
        mode = 2'd3; period = '0; load = 1'b1; load_pat = 16'ha5a5;
        drive();
        load = 1'b0;
        drive_n(5);

        // Freeze mid-count and resume
        mode = 2'd0; dir = 1'b0; period = 27'd20;
        drive_n(7);
        run = 1'b0;
        drive_n(10);
        run = 1'b1;
        drive_n(20);

        // Load coincident with a tick
        period = 27'd3;
        guard = 0;
        while (m_cnt != 2 && guard < 10) begin drive(); guard++; end
        if (m_cnt != 2) begin
            miscompares++;
            $display("FAIL load_on_tick: cnt=%0d, expected 2", m_cnt);
        end
        load = 1'b1; load_pat = 16'h1234;
        drive();
        load = 1'b0;
        drive_n(4);

        // Shrink the period below the running count
        period = 27'd100;
        guard = 0;
        while (m_cnt != 50 && guard < 200) begin drive(); guard++; end
        if (m_cnt != 50) begin
            miscompares++;
            $display("FAIL period_shrink: cnt=%0d, expected 50", m_cnt);
        end
        period = 27'd2;
        drive_n(5);

        // Reset in the middle of a period
        mode = 2'd1; period = 27'd5;
        drive_n(3);
        resetn = 1'b0;
        drive();
        resetn = 1'b1;
        drive_n(12);

        // Random traffic; mode and dir only move on running cycles
        for (int i = 0; i < 2500; i++) begin
            resetn   = ($urandom_range(0, 299) != 0);
            load     = ($urandom_range(0, 19) == 0);
            load_pat = W'($urandom);
            run      = ($urandom_range(0, 7) != 0);
            if (run) begin
                if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
                if ($urandom_range(0, 7) == 0) dir = 1'($urandom);
                if ($urandom_range(0, 31) == 0) period = CNT_W'($urandom_range(0, 5));
            end
            drive();
        end
        load = 1'b0;
        drive_n(2);

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
